gol_gen_sequencer: RTL
======================

Name: gol_gen_sequencer

Overview:
- Holds a W x H Game of Life grid in registers and advances it one generation per accepted step request.
- Evaluates one row per clock using W instances of a per-cell rule unit, writes the results into a shadow buffer, then commits the whole grid at once.
- Sits between the host/load logic and the display/readout path.
- Provides load, step, readback and status (busy, done, generation count, still-life, extinct).

Parameters:
- W, 8, grid width in cells (columns); 3..64.
- H, 8, grid height in rows; 3..64.
- WRAP, 1, 1 = toroidal neighbourhood; 0 = out-of-grid neighbours read as dead.
- GEN_W, 16, generation counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- load_en  in  1  write load_data into grid row load_row (IDLE only).
- load_row  in  $clog2(H)  row index for load.
- load_data  in  W  row contents; bit i = column i, 1 = alive.
- step  in  1  request one generation (single-cycle pulse or level; sampled in IDLE).
- busy  out  1  high while a generation is in progress.
- done  out  1  one-cycle pulse after commit.
- gen_count  out  GEN_W  committed generations since reset.
- still  out  1  last commit left the grid unchanged.
- extinct  out  1  current grid is all dead.
- rd_row  in  $clog2(H)  readback row index.
- rd_data  out  W  registered grid[rd_row]; 1-cycle latency; always live.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - grid and shadow cleared; state IDLE.
  - busy=0, done=0, gen_count=0, still=0, extinct=1, rd_data=0.
  - Reset applied mid-COMPUTE aborts the generation: no commit, no done.
- States:
  - IDLE: load_en writes grid[load_row] <= load_data at the edge. step=1 -> COMPUTE with row counter r=0; busy=1 from the next cycle.
  - COMPUTE: each cycle, shadow[r] <= rule(grid[r-1], grid[r], grid[r+1]). Row indices wrap mod H when WRAP=1; out-of-range rows are zero when WRAP=0. r=H-1 -> COMMIT; otherwise r++.
  - COMMIT: grid <= shadow; still <= (shadow == grid); extinct <= (shadow == 0); gen_count++ (wraps from 2^GEN_W-1 to 0); -> IDLE. done=1 and busy=0 in the following cycle.
- Latency: step sampled at edge T -> busy high for cycles T+1 .. T+H+1 -> done pulse at T+H+2.
- Cell rule (B3/S23): next = (n==3) | (cur & n==2), where n = count of 8 neighbours.
  - Column neighbours wrap mod W when WRAP=1; zero at the edges when WRAP=0.
- Simultaneous load_en and step in IDLE: both accepted. The load lands first, so COMPUTE sees the loaded row.
- load_en or step while busy: ignored, no queueing. gen_count advances exactly once per accepted step.
- step held high: a new generation starts in the cycle after each return to IDLE (back-to-back generations).
- extinct also updates on load: recomputed from the grid every IDLE cycle.
- still is cleared by any load.
- Generation reads only grid; the grid is never modified during COMPUTE.

Decomposition:
- gol_pkg holds:
  - state enum {IDLE, COMPUTE, COMMIT};
  - BIRTH_MASK=9'b000001000 and SURVIVE_MASK=9'b000001100, indexed by neighbour count;
  - a row-index wrap helper function.
- Sub-module gol_cell_rule: inputs cur plus 8 neighbours, output next. Counts neighbours with a 4-bit adder tree and looks up the masks. Instanced W times in a generate loop.

Test Plan:
- Blinker, 8x8, WRAP=1: load row3=8'b00011100, step -> busy for 9 cycles, done pulse. Rows 2,3,4 then read 8'b00001000 and all others 0; gen_count=1. A second step restores the original grid; gen_count=2.
- Block still life: rows 3,4 = 8'b00011000, step -> grid unchanged, still=1, extinct=0.
- Lone cell: row0=8'b00000001, step -> grid all zero, extinct=1. A further step keeps the grid at zero, still=1, gen_count=2.
- Glider, WRAP=1: load at the top-left, 32 steps with step held high -> grid equals the initial pattern (period 4, 8-cell translation wrap), gen_count=32. The same stimulus with WRAP=0 ends with the glider clipped at the edge and a stable (still=1) residue.
- step and load_en pulsed during COMPUTE -> no effect; gen_count increments by 1 only. Loaded row is absent from readback.
- rst_n low for one cycle at COMPUTE r=4 -> next cycle busy=0, grid=0, gen_count=0, extinct=1, and no done pulse.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation sequencer.
// Rule masks are indexed by live-neighbour count (0..8).
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } state_e;

  localparam logic [8:0] BIRTH_MASK   = 9'b000001000;
  localparam logic [8:0] SURVIVE_MASK = 9'b000001100;

  function automatic int row_wrap(
    input int r,
    input int d,
    input int n
  );
    return (r + d + n) % n;
  endfunction

endpackage

// File: rtl/gol_cell_rule.sv
// Single-cell B3/S23 rule: neighbour count via a small adder tree,
// then a lookup into the birth or survive mask.
module gol_cell_rule
  import gol_pkg::*;
(
  input  logic       cur_i,
  input  logic [7:0] nb_i,
  output logic       next_o
);

  logic [1:0] p0, p1, p2, p3;
  logic [2:0] q0, q1;
  logic [3:0] n;

  assign p0 = {1'b0, nb_i[0]} + {1'b0, nb_i[1]};
  assign p1 = {1'b0, nb_i[2]} + {1'b0, nb_i[3]};
  assign p2 = {1'b0, nb_i[4]} + {1'b0, nb_i[5]};
  assign p3 = {1'b0, nb_i[6]} + {1'b0, nb_i[7]};
  assign q0 = {1'b0, p0} + {1'b0, p1};
  assign q1 = {1'b0, p2} + {1'b0, p3};
  assign n  = {1'b0, q0} + {1'b0, q1};

  assign next_o = cur_i ? SURVIVE_MASK[n] : BIRTH_MASK[n];

endmodule

// File: rtl/gol_gen_sequencer.sv
// Register-held Game of Life grid; one row per clock into a shadow
// buffer, whole-grid commit at the end of each generation.
module gol_gen_sequencer
  import gol_pkg::*;
#(
  parameter int W     = 8,
  parameter int H     = 8,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic [$clog2(H)-1:0] load_row,
  input  logic [W-1:0]         load_data,
  input  logic                 step,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 still,
  output logic                 extinct,
  input  logic [$clog2(H)-1:0] rd_row,
  output logic [W-1:0]         rd_data
);

  localparam int RW = $clog2(H);

  state_e           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [W-1:0]     grid_q   [H];
  logic [W-1:0]     shadow_q [H];
  logic [GEN_W-1:0] gen_q;
  logic             done_q, still_q, extinct_q;
  logic [W-1:0]     rd_q;

  logic [W-1:0] up, mid, dn, nxt;
  logic         grid_zero, shadow_zero, same;

  // Rows outside the grid read as dead unless the field is toroidal.
  always_comb begin
    up  = '0;
    dn  = '0;
    mid = grid_q[row_q];
    if (WRAP != 0 || row_q != '0)
      up = grid_q[RW'(row_wrap(int'(row_q), -1, H))];
    if (WRAP != 0 || int'(row_q) != H - 1)
      dn = grid_q[RW'(row_wrap(int'(row_q), 1, H))];
  end

  for (genvar c = 0; c < W; c++) begin : g_col
    localparam int CL    = (c + W - 1) % W;
    localparam int CR    = (c + 1) % W;
    localparam bit HAS_L = (WRAP != 0) || (c != 0);
    localparam bit HAS_R = (WRAP != 0) || (c != W - 1);
    logic [7:0] nb;
    assign nb = {up[CL] & HAS_L, up[c], up[CR] & HAS_R,
                 mid[CL] & HAS_L, mid[CR] & HAS_R,
                 dn[CL] & HAS_L, dn[c], dn[CR] & HAS_R};
    gol_cell_rule u_rule (
      .cur_i  (mid[c]),
      .nb_i   (nb),
      .next_o (nxt[c])
    );
  end

  always_comb begin
    grid_zero   = 1'b1;
    shadow_zero = 1'b1;
    same        = 1'b1;
    for (int i = 0; i < H; i++) begin
      if (grid_q[i] != '0) grid_zero = 1'b0;
      if (shadow_q[i] != '0) shadow_zero = 1'b0;
      if (shadow_q[i] != grid_q[i]) same = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (step) begin
          state_d = COMPUTE;
          row_d   = '0;
        end
      end
      COMPUTE: begin
        if (int'(row_q) == H - 1) state_d = COMMIT;
        else row_d = row_q + RW'(1);
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      gen_q     <= '0;
      done_q    <= 1'b0;
      still_q   <= 1'b0;
      extinct_q <= 1'b1;
      rd_q      <= '0;
      for (int i = 0; i < H; i++) begin
        grid_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      done_q  <= (state_q == COMMIT);
      rd_q    <= grid_q[rd_row];
      unique case (state_q)
        IDLE: begin
          extinct_q <= grid_zero;
          if (load_en) begin
            grid_q[load_row] <= load_data;
            still_q          <= 1'b0;
          end
        end
        COMPUTE: shadow_q[row_q] <= nxt;
        COMMIT: begin
          grid_q    <= shadow_q;
          still_q   <= same;
          extinct_q <= shadow_zero;
          gen_q     <= gen_q + GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign gen_count = gen_q;
  assign still     = still_q;
  assign extinct   = extinct_q;
  assign rd_data   = rd_q;

endmodule
